// File: rtl/change_dispenser.sv
// change_dispenser: takes the change amount that vending_machine reports
// and pays it out as a series of coin requests to the hopper, largest
// denomination first. Each coin request uses a valid/ready handshake.
//
// Optional build macro: COIN_INVENTORY_EN. It adds per-denomination stock
// counters, the refill input and the stock_low output.
//
// Ports:
//   clock        in   system clock; all logic runs on the rising edge
//   reset        in   synchronous, active-high reset
//   change[7:0]  in   amount to pay out; sampled only while trans_sucess=1
//   trans_sucess in   one-cycle strobe that starts a payout
//   coin_ready   in   hopper accepts the pending coin
//   coin_valid   out  a coin request is pending
//   coin_sel[1:0] out denomination code of the pending coin (0 = largest)
//   busy         out  a payout is in progress
//   done         out  one-cycle pulse at the end of every accepted payout
//   residue[7:0] out  unpaid remainder of the last payout
//   overrun      out  one-cycle pulse when a strobe arrives while busy
//   refill       in   (COIN_INVENTORY_EN) reload every stock counter
//   stock_low[3:0] out (COIN_INVENTORY_EN) bit i set when stock i < 2
module change_dispenser #(
  parameter int unsigned DENOM_A = 50,
  parameter int unsigned DENOM_B = 20,
  parameter int unsigned DENOM_C = 10,
  parameter int unsigned DENOM_D = 5
`ifdef COIN_INVENTORY_EN
  ,
  parameter int unsigned INV_INIT = 8
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] change,
  input  logic       trans_sucess,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] residue,
  output logic       overrun
`ifdef COIN_INVENTORY_EN
  ,
  input  logic       refill,
  output logic [3:0] stock_low
`endif
);

  localparam int unsigned W = 8;
  localparam int unsigned N_DENOM = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t       state;
  logic [W-1:0] remaining;
  logic [N_DENOM-1:0] avail;
  logic         pick_found;
  logic [1:0]   pick_sel;

  // Map a coin code to its value.
  function automatic logic [W-1:0] denom_of(input logic [1:0] sel);
    logic [W-1:0] v;
    v = W'(DENOM_D);
    case (sel)
      2'd0:    v = W'(DENOM_A);
      2'd1:    v = W'(DENOM_B);
      2'd2:    v = W'(DENOM_C);
      default: v = W'(DENOM_D);
    endcase
    return v;
  endfunction

`ifdef COIN_INVENTORY_EN
  logic [W-1:0] stock     [N_DENOM];
  logic [W-1:0] stock_nxt [N_DENOM];

  // Next stock: refill has priority over the decrement from an accepted coin.
  always_comb begin
    for (int i = 0; i < N_DENOM; i++) begin
      stock_nxt[i] = stock[i];
      if (refill) begin
        stock_nxt[i] = W'(INV_INIT);
      end else if (state == S_ISSUE && coin_ready && coin_sel == 2'(i)) begin
        stock_nxt[i] = stock[i] - W'(1);
      end
    end
  end

  // Stock counters and their low-water flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_DENOM; i++) begin
        stock[i]     <= W'(INV_INIT);
        stock_low[i] <= (INV_INIT < 2);
      end
    end else begin
      for (int i = 0; i < N_DENOM; i++) begin
        stock[i]     <= stock_nxt[i];
        stock_low[i] <= (stock_nxt[i] < W'(2));
      end
    end
  end
`endif

  // A denomination is usable when it fits the remaining amount (and is in stock).
  always_comb begin
    avail = '0;
    for (int i = 0; i < N_DENOM; i++) begin
      avail[i] = (denom_of(2'(i)) <= remaining);
`ifdef COIN_INVENTORY_EN
      if (stock[i] == '0) avail[i] = 1'b0;
`endif
    end
  end

  // Priority pick: lowest code (largest coin) wins, so scan downwards.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = 2'd0;
    for (int i = N_DENOM - 1; i >= 0; i--) begin
      if (avail[i]) begin
        pick_found = 1'b1;
        pick_sel   = 2'(i);
      end
    end
  end

  // Payout FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      coin_valid <= 1'b0;
      coin_sel   <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      residue    <= '0;
      overrun    <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= trans_sucess && busy;
      case (state)
        S_IDLE: begin
          if (trans_sucess) begin
            remaining <= change;
            residue   <= '0;
            if (change == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_SELECT;
              busy  <= 1'b1;
            end
          end
        end
        S_SELECT: begin
          if (pick_found) begin
            coin_sel   <= pick_sel;
            coin_valid <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            residue <= remaining;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_ISSUE: begin
          // SELECT guaranteed denom <= remaining, so no underflow here.
          if (coin_ready) begin
            remaining  <= remaining - denom_of(coin_sel);
            coin_valid <= 1'b0;
            state      <= S_SELECT;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
